// File: rtl/demux_pkg.sv
// Shared types and default sizing for the TDM demultiplexer.
// The DEMUX_HOLD_EN build option is applied in demux_lane_reg.
package demux_pkg;

    localparam int DEMUX_DW  = 8;
    localparam int DEMUX_NCH = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } demux_state_t;

    // Channel counter width; a single lane would still need one bit.
    function automatic int demux_cw(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/demux_lane_reg.sv
// One output lane of the TDM demultiplexer: registered sample plus a valid pulse.
// With DEMUX_HOLD_EN the sample is kept until overwritten; otherwise it reads 0 outside its pulse.
module demux_lane_reg #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic [DW-1:0] i_data,
    output logic [DW-1:0] o_data,
    output logic          o_valid
);

    logic [DW-1:0] r_data;
    logic          r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= i_load;
            if (i_load) begin
                r_data <= i_data;
            end else begin
`ifdef DEMUX_HOLD_EN
                r_data <= r_data;
`else
                r_data <= '0;
`endif
            end
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/demux4_tdm.sv
// Framed TDM demultiplexer: steers a serial sample stream onto NCH registered lanes.
// Lane hold-versus-clear behaviour is selected by the DEMUX_HOLD_EN macro.
//
// state | meaning
// IDLE  | unlocked; samples dropped until a valid start-of-frame
// RUN   | locked; each valid sample goes to lane ch, ch advances
module demux4_tdm
    import demux_pkg::*;
#(
    parameter int DW  = DEMUX_DW,
    parameter int NCH = DEMUX_NCH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DW-1:0]     in_data,
    input  logic              in_valid,
    input  logic              in_sof,
    output logic [NCH*DW-1:0] out_data,
    output logic [NCH-1:0]    out_valid,
    output logic              frame_done,
    output logic              frame_err,
    output logic              locked
);

    localparam int            CW      = demux_cw(NCH);
    localparam logic [CW-1:0] LAST_CH = CW'(NCH - 1);
    localparam logic [CW-1:0] CH_ONE  = CW'(1);

    demux_state_t  r_state;
    demux_state_t  w_state_nxt;
    logic [CW-1:0] r_ch;
    logic [CW-1:0] w_ch_nxt;
    logic          r_frame_done;
    logic          r_frame_err;
    logic [NCH-1:0] w_load;
    logic          w_done;
    logic          w_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_ch         <= '0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ch         <= w_ch_nxt;
            r_frame_done <= w_done;
            r_frame_err  <= w_err;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ch_nxt    = r_ch;
        if (in_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (in_sof) begin
                        w_state_nxt = ST_RUN;
                        w_ch_nxt    = CH_ONE;
                    end
                end
                ST_RUN: begin
                    if (in_sof) begin
                        w_ch_nxt = CH_ONE;
                    end else if (r_ch == '0) begin
                        w_state_nxt = ST_IDLE;
                        w_ch_nxt    = '0;
                    end else if (r_ch == LAST_CH) begin
                        w_ch_nxt = '0;
                    end else begin
                        w_ch_nxt = r_ch + CH_ONE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_ch_nxt    = '0;
                end
            endcase
        end
    end

    // An sof at ch==0 in RUN is simply the start of the next good frame.
    always_comb begin
        w_load = '0;
        w_done = 1'b0;
        w_err  = 1'b0;
        if (in_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (in_sof) begin
                        w_load[0] = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (in_sof) begin
                        w_load[0] = 1'b1;
                        w_err     = (r_ch != '0);
                    end else if (r_ch == '0) begin
                        w_err = 1'b1;
                    end else begin
                        w_load[r_ch] = 1'b1;
                        w_done       = (r_ch == LAST_CH);
                    end
                end
                default: begin
                    w_load = '0;
                end
            endcase
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_lane
        demux_lane_reg #(
            .DW (DW)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_load  (w_load[k]),
            .i_data  (in_data),
            .o_data  (out_data[k*DW +: DW]),
            .o_valid (out_valid[k])
        );
    end

    assign frame_done = r_frame_done;
    assign frame_err  = r_frame_err;
    assign locked     = (r_state == ST_RUN);

endmodule

// File: tb/tb_demux4_tdm.sv
// Self-checking bench for demux4_tdm: directed frames followed by random traffic,
// compared against a frame-position model. Honours DEMUX_HOLD_EN like the design.
module tb_demux4_tdm;

    localparam int DW  = 8;
    localparam int NCH = 4;
`ifdef DEMUX_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic [DW-1:0]     in_data;
    logic              in_valid;
    logic              in_sof;
    logic [NCH*DW-1:0] out_data;
    logic [NCH-1:0]    out_valid;
    logic              frame_done;
    logic              frame_err;
    logic              locked;

    demux4_tdm #(.DW(DW), .NCH(NCH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .locked     (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Model: which lane the next sample should land in, and whether we are framed.
    bit [DW-1:0]  m_lane [NCH];
    bit [NCH-1:0] m_vld;
    bit           m_done;
    bit           m_err;
    bit           m_locked;
    int           m_pos;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) m_lane[k] = '0;
        m_vld = '0; m_done = 0; m_err = 0; m_locked = 0; m_pos = 0;
    endtask

    task automatic model_accept(input int k, input bit [DW-1:0] d);
        m_lane[k] = d;
        m_vld[k]  = 1'b1;
    endtask

    task automatic model_step(input bit v, input bit s, input bit [DW-1:0] d);
        m_vld = '0; m_done = 0; m_err = 0;
        if (v) begin
            if (!m_locked) begin
                if (s) begin
                    model_accept(0, d); m_pos = 1; m_locked = 1;
                end
            end else if (s) begin
                m_err = (m_pos != 0);
                model_accept(0, d); m_pos = 1;
            end else if (m_pos == 0) begin
                m_err = 1; m_locked = 0;
            end else begin
                model_accept(m_pos, d);
                m_pos = m_pos + 1;
                if (m_pos == NCH) begin
                    m_done = 1; m_pos = 0;
                end
            end
        end
    endtask

    function automatic logic [NCH*DW-1:0] model_data();
        logic [NCH*DW-1:0] r;
        r = '0;
        for (int k = 0; k < NCH; k++)
            if (HOLD || m_vld[k]) r[k*DW +: DW] = m_lane[k];
        return r;
    endfunction

    task automatic check_model(input string tag);
        chk({tag, ".data"},   out_data,   model_data());
        chk({tag, ".valid"},  out_valid,  m_vld);
        chk({tag, ".done"},   frame_done, m_done);
        chk({tag, ".err"},    frame_err,  m_err);
        chk({tag, ".locked"}, locked,     m_locked);
    endtask

    task automatic step(input string tag, input bit v, input bit s, input bit [DW-1:0] d);
        @(negedge clk);
        in_valid = v; in_sof = s; in_data = d;
        @(posedge clk);
        model_step(v, s, d);
        #1;
        check_model(tag);
    endtask

    task automatic gap(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 8'($urandom));
    endtask

    task automatic good_frame(input string tag, input int gaps);
        logic [DW-1:0] vals [NCH];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
        for (int k = 0; k < NCH; k++) begin
            step(tag, 1'b1, k == 0, vals[k]);
            chk({tag, ".pulse"}, out_valid, 4'b0001 << k);
            if (k < NCH - 1) gap(tag, gaps);
        end
        chk({tag, ".fdone"}, frame_done, 1'b1);
        chk({tag, ".lane3"}, out_data[31:24], 8'h44);
        chk({tag, ".lock"}, locked, 1'b1);
    endtask

    initial begin
        bit v, s;
        rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Test 1: back-to-back good frame, then observe lane 0 hold/clear.
        good_frame("t1", 0);
        chk("t1.err_free", frame_err, 1'b0);
        step("t6", 1'b0, 1'b0, 8'h00);
        chk("t6.lane0", out_data[7:0], HOLD ? 8'h11 : 8'h00);

        // Test 2: same frame with 2-cycle gaps.
        good_frame("t2", 2);

        // Test 3: short frame, sof after two samples.
        step("t3", 1'b1, 1'b1, 8'hA0);
        step("t3", 1'b1, 1'b0, 8'hA1);
        step("t3", 1'b1, 1'b1, 8'hB0);
        chk("t3.err", frame_err, 1'b1);
        chk("t3.lane0", out_data[7:0], 8'hB0);
        step("t3", 1'b1, 1'b0, 8'hB1);
        chk("t3.next_lane1", out_valid, 4'b0010);
        step("t3", 1'b1, 1'b0, 8'hB2);
        step("t3", 1'b1, 1'b0, 8'hB3);
        chk("t3.done", frame_done, 1'b1);

        // Test 4: missing sof after a good frame drops lock.
        step("t4", 1'b1, 1'b0, 8'h55);
        chk("t4.err", frame_err, 1'b1);
        chk("t4.novalid", out_valid, 4'b0000);
        chk("t4.unlocked", locked, 1'b0);
        step("t4", 1'b1, 1'b0, 8'h56);
        step("t4", 1'b1, 1'b0, 8'h57);
        chk("t4.ignored", out_valid, 4'b0000);

        // Test 5: reset mid-frame clears everything asynchronously.
        step("t5", 1'b1, 1'b1, 8'hC0);
        step("t5", 1'b1, 1'b0, 8'hC1);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("t5.async_data", out_data, '0);
        chk("t5.async_valid", out_valid, '0);
        chk("t5.async_locked", locked, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step("t5", 1'b1, 1'b0, 8'hC2);
        step("t5", 1'b1, 1'b0, 8'hC3);
        chk("t5.post_ignored", out_valid, 4'b0000);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 3) != 0);
            s = (m_pos == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) == 0);
            step("rand", v, s, 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
